// File: rtl/uart_rx_keys_if.sv
// Serial receive link between the RX pin side and the navigation/menu FSM:
// raw rx line in, received byte, key code and status strobes out.
interface uart_rx_keys_if;
  logic       rx;
  logic [7:0] dout_byte;
  logic       dout_rdy;
  logic       frame_err;
  logic [2:0] kcode;
  logic       key_tick;
  logic       rx_busy;

  modport master (
    output rx,
    input  dout_byte, dout_rdy, frame_err, kcode, key_tick, rx_busy
  );

  modport slave (
    input  rx,
    output dout_byte, dout_rdy, frame_err, kcode, key_tick, rx_busy
  );
endinterface

// File: rtl/uart_rx_keys.sv
// 8N1 UART receiver that also turns bytes 0x01-0x05 into front-panel key codes
// so a remote host can emulate button presses.
module uart_rx_keys #(
  parameter int crystal = 22118400,
  parameter int baud    = 9600
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_keys_if.slave  bus
);

  localparam int DIV  = crystal / baud;
  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  if (DIV < 4) begin : g_divCheck
    $error("uart_rx_keys: crystal/baud must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_sync;
  logic          w_rxS;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bidx;
  logic [7:0]    r_shift;
  logic          w_sample;
  logic          w_good;
  logic          w_bad;
  logic          w_isKey;

  logic [7:0]    r_doutByte;
  logic          r_doutRdy;
  logic          r_frameErr;
  logic [2:0]    r_kcode;
  logic          r_keyTick;
  logic          r_busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.rx};
    end
  end

  assign w_rxS = r_sync[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    w_good   = 1'b0;
    w_bad    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxS) w_next = S_START;
      end
      S_START: begin
        if (r_cnt == CNT_HALF) w_next = w_rxS ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_sample = 1'b1;
          if (r_bidx == 3'd7) w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          if (w_rxS) begin
            w_good = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_bad  = 1'b1;
            w_next = S_WAIT_HI;
          end
        end
      end
      S_WAIT_HI: begin
        if (w_rxS) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_isKey = (r_shift[7:3] == 5'd0) && (r_shift[2:0] >= 3'd1) && (r_shift[2:0] <= 3'd5);

  // The counter restarts on every state change and at each full bit time,
  // so every data sample lands DIV clocks after the previous one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_bidx     <= 3'd0;
      r_shift    <= 8'h00;
      r_doutByte <= 8'h00;
      r_doutRdy  <= 1'b0;
      r_frameErr <= 1'b0;
      r_kcode    <= 3'd0;
      r_keyTick  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if ((w_next != r_state) || (r_state == S_IDLE) || (r_state == S_WAIT_HI)) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      if ((r_state == S_START) && (w_next == S_DATA)) begin
        r_bidx <= 3'd0;
      end else if (w_sample) begin
        r_bidx <= r_bidx + 3'd1;
      end

      if (w_sample) r_shift <= {w_rxS, r_shift[7:1]};

      r_doutRdy  <= w_good;
      r_frameErr <= w_bad;
      r_keyTick  <= w_good && w_isKey;
      if (w_good) r_doutByte <= r_shift;
      if (w_good && w_isKey) r_kcode <= r_shift[2:0];
      r_busy <= (w_next != S_IDLE);
    end
  end

  assign bus.dout_byte = r_doutByte;
  assign bus.dout_rdy  = r_doutRdy;
  assign bus.frame_err = r_frameErr;
  assign bus.kcode     = r_kcode;
  assign bus.key_tick  = r_keyTick;
  assign bus.rx_busy   = r_busy;

endmodule

// File: tb/tb_uart_rx_keys.sv
// Directed bench for uart_rx_keys at DIV=16: good frames, key decode,
// back-to-back bytes, glitch rejection, framing error with break, reset abort.
module tb_uart_rx_keys;

  localparam int DIV = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  uart_rx_keys_if bus ();

  uart_rx_keys #(
    .crystal(1600),
    .baud   (100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks = 0;
  int fails = 0;
  int cycleCount = 0;
  int rdyCount = 0;
  int tickCount = 0;
  int errCount = 0;
  int orphanTicks = 0;
  int bothCount = 0;
  int lastRdyCycle = 0;
  int startCycle = 0;
  logic [7:0] lastByte = 8'h00;
  logic [7:0] prevByte = 8'h00;

  always @(posedge clk) cycleCount++;

  // Pulse monitor on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (bus.dout_rdy === 1'b1) begin
      rdyCount++;
      prevByte = lastByte;
      lastByte = bus.dout_byte;
      lastRdyCycle = cycleCount;
    end
    if (bus.key_tick === 1'b1) begin
      tickCount++;
      if (bus.dout_rdy !== 1'b1) orphanTicks++;
    end
    if (bus.frame_err === 1'b1) begin
      errCount++;
      if (bus.dout_rdy === 1'b1) bothCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic driveBit(input logic v);
    @(posedge clk);
    #1;
    bus.rx = v;
    repeat (DIV - 1) @(posedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    @(posedge clk);
    #1;
    bus.rx = 1'b0;
    startCycle = cycleCount;
    repeat (DIV - 1) @(posedge clk);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit(stopBit);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.rx = 1'b0;
    reset  = 1'b0;
    waitCycles(3);
    checkOutput("reset dout_byte", 32'(bus.dout_byte), 32'h00);
    checkOutput("reset dout_rdy", 32'(bus.dout_rdy), 32'h0);
    checkOutput("reset frame_err", 32'(bus.frame_err), 32'h0);
    checkOutput("reset kcode", 32'(bus.kcode), 32'h0);
    checkOutput("reset key_tick", 32'(bus.key_tick), 32'h0);
    checkOutput("reset rx_busy", 32'(bus.rx_busy), 32'h0);

    reset  = 1'b1;
    bus.rx = 1'b1;
    waitCycles(20);
    checkOutput("idle busy", 32'(bus.rx_busy), 32'h0);
    checkOutput("idle no rdy", 32'(rdyCount), 32'd0);

    // Key byte 0x03
    applyStimulus(8'h03, 1'b1);
    waitCycles(10);
    checkOutput("k3 rdy count", 32'(rdyCount), 32'd1);
    checkOutput("k3 byte", 32'(lastByte), 32'h03);
    checkOutput("k3 dout_byte", 32'(bus.dout_byte), 32'h03);
    checkOutput("k3 tick count", 32'(tickCount), 32'd1);
    checkOutput("k3 kcode", 32'(bus.kcode), 32'd3);
    checkOutput("k3 latency", 32'(lastRdyCycle - startCycle), 32'd155);

    // Back-to-back non-key bytes
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h06, 1'b1);
    waitCycles(10);
    checkOutput("b2b rdy count", 32'(rdyCount), 32'd3);
    checkOutput("b2b first byte", 32'(prevByte), 32'hA5);
    checkOutput("b2b second byte", 32'(lastByte), 32'h06);
    checkOutput("b2b tick count", 32'(tickCount), 32'd1);
    checkOutput("b2b kcode held", 32'(bus.kcode), 32'd3);

    // Five-clock low glitch
    @(posedge clk);
    #1;
    bus.rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.rx = 1'b1;
    checkOutput("glitch busy", 32'(bus.rx_busy), 32'h1);
    waitCycles(6);
    checkOutput("glitch busy dropped", 32'(bus.rx_busy), 32'h0);
    waitCycles(30);
    checkOutput("glitch no rdy", 32'(rdyCount), 32'd3);
    checkOutput("glitch no err", 32'(errCount), 32'd0);

    // Framing error followed by a held-low break
    applyStimulus(8'h55, 1'b0);
    waitCycles(100);
    bus.rx = 1'b1;
    waitCycles(20);
    checkOutput("ferr count", 32'(errCount), 32'd1);
    checkOutput("ferr no rdy", 32'(rdyCount), 32'd3);
    checkOutput("ferr byte kept", 32'(bus.dout_byte), 32'h06);
    applyStimulus(8'h01, 1'b1);
    waitCycles(10);
    checkOutput("k1 rdy count", 32'(rdyCount), 32'd4);
    checkOutput("k1 byte", 32'(lastByte), 32'h01);
    checkOutput("k1 tick count", 32'(tickCount), 32'd2);
    checkOutput("k1 kcode", 32'(bus.kcode), 32'd1);

    // Reset during data bit 4 of 0x02
    @(posedge clk);
    #1;
    bus.rx = 1'b0;
    repeat (DIV - 1) @(posedge clk);
    for (int i = 0; i < 4; i++) driveBit(1'(8'h02 >> i));
    @(posedge clk);
    #1;
    bus.rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    waitCycles(1);
    checkOutput("abort busy", 32'(bus.rx_busy), 32'h0);
    checkOutput("abort kcode", 32'(bus.kcode), 32'h0);
    reset  = 1'b1;
    bus.rx = 1'b1;
    waitCycles(200);
    checkOutput("abort no rdy", 32'(rdyCount), 32'd4);
    checkOutput("abort no err", 32'(errCount), 32'd1);
    checkOutput("abort no tick", 32'(tickCount), 32'd2);
    applyStimulus(8'h02, 1'b1);
    waitCycles(10);
    checkOutput("k2 rdy count", 32'(rdyCount), 32'd5);
    checkOutput("k2 byte", 32'(lastByte), 32'h02);
    checkOutput("k2 kcode", 32'(bus.kcode), 32'd2);
    checkOutput("k2 tick count", 32'(tickCount), 32'd3);

    checkOutput("tick without rdy", 32'(orphanTicks), 32'd0);
    checkOutput("rdy with err", 32'(bothCount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
